// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Holds the request bundle and the starvation FSM state encoding.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int RAW   = 5;
  localparam int NREGS = 1 << RAW;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  sel;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    PRIO_B = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Starvation guard for the long-latency writeback port: counts refused B cycles
// and hands priority to B once it has been refused MAX_WAIT times in a row.
module wb_starve_ctr
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b_valid,
  input  logic       b_ready,
  output logic       b_starved,
  output arb_state_t state
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic [3:0] cnt_next;

  always_comb begin
    // NOTE: default first so every path assigns cnt_next and no latch is inferred.
    cnt_next = wait_cnt;
    if (!b_valid || b_ready) begin
      cnt_next = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      cnt_next = wait_cnt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      state     <= NORMAL;
      b_starved <= 1'b0;
    end else begin
      wait_cnt <= cnt_next;
      case (state)
        NORMAL: begin
          if (cnt_next == WAIT_MAX) begin
            state     <= PRIO_B;
            b_starved <= 1'b1;
          end
        end
        PRIO_B: begin
          // Priority is released once B is served or withdraws.
          if (!b_valid || b_ready) begin
            state     <= NORMAL;
            b_starved <= 1'b0;
          end
        end
        default: begin
          state     <= NORMAL;
          b_starved <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between pipeline (A) and long-latency (B)
// writebacks. Define REGFILE_WB_SCOREBOARD_EN to add the pending-destination scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [RAW-1:0]  a_sel,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [RAW-1:0]  b_sel,
  input  logic [XLEN-1:0] b_data,
  output logic            wr_en,
  output logic [RAW-1:0]  wr_sel,
  output logic [XLEN-1:0] wr_data,
  output logic            b_starved
`ifdef REGFILE_WB_SCOREBOARD_EN
  ,
  input  logic            alloc_valid,
  input  logic [RAW-1:0]  alloc_sel,
  input  logic [RAW-1:0]  rs1sel,
  input  logic [RAW-1:0]  rs2sel,
  output logic            hazard
`endif
);

  arb_state_t state;
  wb_req_t    a_req;
  wb_req_t    b_req;
  wb_req_t    win;

  wb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_starved (b_starved),
    .state     (state)
  );

  assign a_req = '{valid: a_valid, sel: a_sel, data: a_data};
  assign b_req = '{valid: b_valid, sel: b_sel, data: b_data};

  // A wins by default; a starved B pre-empts it.
  assign a_ready = a_valid && !b_starved;
  assign b_ready = b_valid && (b_starved || !a_valid);

  always_comb begin
    win       = a_req;
    win.valid = a_ready;
    if (b_ready) begin
      win       = b_req;
      win.valid = 1'b1;
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= win.valid && (win.sel != '0);
      if (win.valid && (win.sel != '0)) begin
        wr_sel  <= win.sel;
        wr_data <= win.data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_set;
  logic [NREGS-1:0] pend_clr;

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (alloc_valid && (alloc_sel != '0)) pend_set[alloc_sel] = 1'b1;
    if (b_ready) pend_clr[b_sel] = 1'b1;
  end

  // Set is applied after clear so a same-cycle alloc of a retiring register survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end

  assign hazard = pend[rs1sel] | pend[rs2sel];
`endif

  grant_onehot: assert property (@(posedge clk) !(a_ready && b_ready));
  starve_matches_state: assert property (@(posedge clk) disable iff (reset)
    b_starved == (state == PRIO_B));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed cases then randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [RAW-1:0]  a_sel = '0;
  logic [XLEN-1:0] a_data = '0;
  logic            b_valid = 1'b0;
  logic            b_ready;
  logic [RAW-1:0]  b_sel = '0;
  logic [XLEN-1:0] b_data = '0;
  logic            wr_en;
  logic [RAW-1:0]  wr_sel;
  logic [XLEN-1:0] wr_data;
  logic            b_starved;
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic            alloc_valid = 1'b0;
  logic [RAW-1:0]  alloc_sel = '0;
  logic [RAW-1:0]  rs1sel = '0;
  logic [RAW-1:0]  rs2sel = '0;
  logic            hazard;
  bit              pend_m [NREGS];
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_sel     (a_sel),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_sel     (b_sel),
    .b_data    (b_data),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .b_starved (b_starved)
`ifdef REGFILE_WB_SCOREBOARD_EN
    ,
    .alloc_valid (alloc_valid),
    .alloc_sel   (alloc_sel),
    .rs1sel      (rs1sel),
    .rs2sel      (rs2sel),
    .hazard      (hazard)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: refusal count, expected write presented next cycle, register file.
  int         m_refused = 0;
  bit         m_en = 0;
  bit         m_zero = 1;
  bit [4:0]   m_sel = 0;
  bit [31:0]  m_data = 0;
  bit [31:0]  model_rf [NREGS];
  bit [31:0]  seen_rf  [NREGS];

  // Values observed during the most recent step, for directed checks.
  logic       obs_ar, obs_br, obs_bs, obs_en;
  logic [4:0] obs_sel;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are already driven; settle, compare, advance the model, then cross one edge.
  task automatic step();
    bit starve, ga, gb;
    #1;
    obs_ar = a_ready; obs_br = b_ready; obs_bs = b_starved;
    obs_en = wr_en; obs_sel = wr_sel; obs_data = wr_data;

    check("wr_en", {31'd0, wr_en}, {31'd0, m_en});
    if (m_en) begin
      check("wr_sel", {27'd0, wr_sel}, {27'd0, m_sel});
      check("wr_data", wr_data, m_data);
      seen_rf[wr_sel] = wr_data;
    end
    if (m_zero) begin
      check("wr_sel_zero", {27'd0, wr_sel}, 32'd0);
      check("wr_data_zero", wr_data, 32'd0);
    end

    starve = (m_refused >= MAX_WAIT);
    gb = b_valid && (starve || !a_valid);
    ga = a_valid && !gb;
    check("b_starved", {31'd0, b_starved}, {31'd0, starve});
    check("a_ready", {31'd0, a_ready}, {31'd0, ga});
    check("b_ready", {31'd0, b_ready}, {31'd0, gb});
`ifdef REGFILE_WB_SCOREBOARD_EN
    check("hazard", {31'd0, hazard}, {31'd0, pend_m[rs1sel] | pend_m[rs2sel]});
`endif

    if (reset) begin
      m_en = 0; m_zero = 1; m_refused = 0;
`ifdef REGFILE_WB_SCOREBOARD_EN
      foreach (pend_m[i]) pend_m[i] = 0;
`endif
    end else begin
      bit [4:0]  s;
      bit [31:0] d;
      s = gb ? b_sel : a_sel;
      d = gb ? b_data : a_data;
      m_en = (ga || gb) && (s != 0);
      if (m_en) begin
        m_sel = s; m_data = d; m_zero = 0;
        model_rf[s] = d;
      end
      if (b_valid && !gb) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
      else m_refused = 0;
`ifdef REGFILE_WB_SCOREBOARD_EN
      if (gb) pend_m[b_sel] = 0;
      if (alloc_valid && alloc_sel != 0) pend_m[alloc_sel] = 1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0;
`ifdef REGFILE_WB_SCOREBOARD_EN
    alloc_valid = 0;
`endif
  endtask

  initial begin
    foreach (model_rf[i]) begin model_rf[i] = 0; seen_rf[i] = 0; end
    @(posedge clk);
    #1;

    // Reset: ready follows valid even while reset is held, outputs stay zero.
    reset = 1; a_valid = 1; a_sel = 3; a_data = 32'h1;
    step();
    check("rst_a_ready", {31'd0, obs_ar}, 32'd1);
    step();
    reset = 0; idle();
    step();
    check("rst_wr_en", {31'd0, obs_en}, 32'd0);
    check("rst_starved", {31'd0, obs_bs}, 32'd0);

    // A only.
    a_valid = 1; a_sel = 3; a_data = 32'hDEADBEEF;
    step();
    check("a_only_ready", {31'd0, obs_ar}, 32'd1);
    idle();
    step();
    check("a_only_en", {31'd0, obs_en}, 32'd1);
    check("a_only_sel", {27'd0, obs_sel}, 32'd3);
    check("a_only_data", obs_data, 32'hDEADBEEF);

    // Starvation: A held continuously, B refused MAX_WAIT cycles then served.
    b_valid = 1; b_sel = 9; b_data = 32'hB0B0_0009;
    for (int i = 0; i < MAX_WAIT; i++) begin
      a_valid = 1; a_sel = 5'(10 + i); a_data = 32'hA000_0000 + i;
      step();
      check("starve_refused", {31'd0, obs_br}, 32'd0);
    end
    a_valid = 1; a_sel = 20; a_data = 32'hA0A0_0020;
    step();
    check("starve_bs", {31'd0, obs_bs}, 32'd1);
    check("starve_br", {31'd0, obs_br}, 32'd1);
    check("starve_ar", {31'd0, obs_ar}, 32'd0);
    b_valid = 0; a_valid = 1; a_sel = 20;
    step();
    check("starve_b_sel", {27'd0, obs_sel}, 32'd9);
    check("starve_cleared", {31'd0, obs_bs}, 32'd0);
    idle();
    step();

    // B write to x0.
    b_valid = 1; b_sel = 0; b_data = 32'h5555_5555;
    step();
    check("x0_b_ready", {31'd0, obs_br}, 32'd1);
    idle();
    step();
    check("x0_no_write", {31'd0, obs_en}, 32'd0);

    // Reset coinciding with an A transfer drops the write.
    a_valid = 1; a_sel = 4; a_data = 32'h4444_4444; reset = 1;
    step();
    reset = 0; idle();
    step();
    check("rst_drop_en", {31'd0, obs_en}, 32'd0);
    check("rst_drop_sel", {27'd0, obs_sel}, 32'd0);
    step();

    // Alternating A/B on the same register: later write wins.
    a_valid = 1; a_sel = 5; a_data = 32'h1111_1111; step();
    idle(); b_valid = 1; b_sel = 5; b_data = 32'h2222_2222; step();
    check("alt_first", obs_data, 32'h1111_1111);
    idle(); a_valid = 1; a_sel = 5; a_data = 32'h3333_3333; step();
    check("alt_second", obs_data, 32'h2222_2222);
    idle(); step();
    check("alt_third", obs_data, 32'h3333_3333);
    step();
    check("alt_holds", seen_rf[5], 32'h3333_3333);

`ifdef REGFILE_WB_SCOREBOARD_EN
    // Scoreboard: alloc, hazard, clear on B retire, set wins over clear.
    alloc_valid = 1; alloc_sel = 7; step();
    alloc_valid = 0; rs1sel = 7; rs2sel = 0; step();
    check("sb_hazard_set", {31'd0, hazard}, 32'd1);
    b_valid = 1; b_sel = 7; b_data = 32'h7777_7777; step();
    b_valid = 0; step();
    check("sb_hazard_clr", {31'd0, hazard}, 32'd0);
    alloc_valid = 1; alloc_sel = 7; step();
    b_valid = 1; b_sel = 7; alloc_valid = 1; alloc_sel = 7; step();
    idle(); step();
    check("sb_set_wins", {31'd0, hazard}, 32'd1);
    reset = 1; step(); reset = 0; step();
`endif

    // Randomized traffic; requesters hold a request until it is accepted.
    idle();
    for (int n = 0; n < 600; n++) begin
      if (!a_valid || obs_ar) begin
        a_valid = ($urandom_range(3) != 0);
        a_sel = 5'($urandom_range(31));
        a_data = $urandom();
      end
      if (!b_valid || obs_br) begin
        b_valid = ($urandom_range(4) < 2);
        b_sel = 5'($urandom_range(31));
        b_data = $urandom();
      end
`ifdef REGFILE_WB_SCOREBOARD_EN
      alloc_valid = ($urandom_range(3) == 0);
      alloc_sel = 5'($urandom_range(31));
      rs1sel = 5'($urandom_range(31));
      rs2sel = 5'($urandom_range(31));
`endif
      reset = ($urandom_range(99) == 0);
      step();
      if (reset) begin
        a_valid = 0; b_valid = 0;
      end
    end
    reset = 0; idle();
    step();
    step();

    foreach (model_rf[i]) check($sformatf("rf_x%0d", i), seen_rf[i], model_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
